// File: rtl/uart_tx_mmio.sv
`timescale 1ns/1ps
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO, STATUS and CTRL registers
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hit_o,
  output logic        tx_o,
  output logic        busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf, r_en;
  logic [31:0]   w_rel, w_status;
  logic [1:0]    w_off;
  logic          w_full, w_empty, w_push_req, w_push, w_pop, w_ovf_evt, w_st_rd, w_bit_end;
  logic          w_unused;
  assign w_rel      = addr_i - BASE_ADDR;
  assign hit_o      = w_rel < 32'd16;
  assign w_off      = w_rel[3:2];
  assign w_unused   = ^{data_i[31:8], w_rel[1:0]};
  assign w_full     = r_cnt == CW'(FIFO_DEPTH);
  assign w_empty    = r_cnt == '0;
  assign w_push_req = hit_o && wr_en_i && w_off == 2'd0;
  assign w_pop      = r_state == IDLE && r_en && !w_empty;
  // A pop on the same edge frees the slot, so a push at full still lands
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_evt  = w_push_req && w_full && !w_pop;
  assign w_st_rd    = hit_o && rd_en_i && w_off == 2'd1;
  assign w_bit_end  = r_baud == BW'(CLKS_PER_BIT - 1);
  assign w_status   = {23'd0, 5'(r_cnt), r_ovf, r_state != IDLE, w_empty, w_full};
  assign data_o     = !(hit_o && rd_en_i) ? '0 :
                      w_off == 2'd1 ? w_status :
                      w_off == 2'd2 ? {31'd0, r_en} : '0;
  assign tx_o       = r_tx;
  assign busy_o     = r_state != IDLE || !w_empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_en  <= 1'b1;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_ovf <= w_ovf_evt || (r_ovf && !w_st_rd);
      if (hit_o && wr_en_i && w_off == 2'd2) r_en <= data_i[0];
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= data_i[7:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_state_nxt = START;
      START:   if (w_bit_end) w_state_nxt = DATA;
      DATA:    if (w_bit_end && r_bit == 3'd7) w_state_nxt = STOP;
      STOP:    if (w_bit_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // The line bit always follows shift[0] while in DATA; the register shifts at each bit end
  always_comb begin
    w_baud_nxt  = (r_state == IDLE || w_bit_end) ? '0 : r_baud + BW'(1);
    w_bit_nxt   = r_state != DATA ? '0 : w_bit_end ? r_bit + 3'd1 : r_bit;
    w_shift_nxt = w_pop ? r_mem[r_rp] : (r_state == DATA && w_bit_end) ? r_shift >> 1 : r_shift;
    w_tx_nxt    = w_state_nxt == START ? 1'b0 : w_state_nxt == DATA ? w_shift_nxt[0] : 1'b1;
  end
endmodule
